missile_ctl: RTL and testbench
==============================

Name: missile_ctl

Overview:
- Game-logic producer of the missile position and visibility consumed by the missile draw stage in the ship pipeline.
- Launches a missile from the current ship position on a fire request and moves it upward a fixed step per video frame.
- Removes the missile at the top of the screen or on a hit, then enforces a frame-counted cooldown.
- Outputs xpos/ypos/on are registered; they are stable for the whole frame apart from launch and hit updates.

Parameters:
- SPEED, 8: pixels the missile moves up per frame tick.
- MISSILE_H, 20: missile height in pixels; launch y = ship_ypos - MISSILE_H.
- COOLDOWN_FRAMES, 4: frame ticks spent in COOLDOWN before a new launch is allowed (legal range 1..15).

Ports:
- pclk  in  1  pixel clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- fire  in  1  fire button, already synchronous to pclk and debounced.
- ship_xpos  in  11  ship left x.
- ship_ypos  in  11  ship top y.
- vsync_in  in  1  vertical sync from the timing stage; its rising edge is the frame tick.
- hit  in  1  collision flag; removes an active missile.
- xpos  out  11  missile x; equals ship x at launch. The draw stage adds the centring offset.
- ypos  out  11  missile top y.
- on  out  1  missile visible.
- shot  out  1  one-cycle pulse on launch (sound/score hook).

Behaviour:
- Reset (async, rst_n=0): xpos=0, ypos=0, on=0, shot=0, state=IDLE, cooldown counter=0, edge-detect registers=0. Effective immediately, including mid-flight.
- Edge detection:
  - frame_tick = vsync_in & ~vsync_q.
  - fire_edge = fire & ~fire_q.
  - vsync_q and fire_q are registered every cycle.
- IDLE: on=0.
  - Condition: fire_edge.
  - Next cycle: xpos<=ship_xpos, on<=1, shot<=1 for exactly one cycle, state goes to FLY.
  - ypos<=ship_ypos-MISSILE_H when ship_ypos>=MISSILE_H, else 0. Compare in 11 bits; never wrap.
- FLY, evaluated in priority order:
  1. hit=1 gives on<=0, counter<=COOLDOWN_FRAMES, state goes to COOLDOWN. Hit wins over a simultaneous frame_tick.
  2. frame_tick with ypos>=SPEED gives ypos<=ypos-SPEED.
  3. frame_tick with ypos<SPEED gives on<=0, counter<=COOLDOWN_FRAMES, state goes to COOLDOWN. ypos holds its last value.
  - xpos holds for the whole flight; ship movement does not drag the missile.
- COOLDOWN: on=0.
  - Each frame_tick decrements the counter.
  - When a tick arrives with counter==1: counter<=0, state goes to IDLE.
- Fire handling:
  - fire_edge in FLY or COOLDOWN is discarded, not queued.
  - Holding fire across the return to IDLE does not launch; a new rising edge is required.
- hit outside FLY is ignored.
- shot is 0 in every cycle except the launch cycle.
- Latency:
  - Launch: fire rising edge at cycle n gives on=1 at n+1.
  - Hit: hit at cycle n gives on=0 at n+1.
- Counter width: 4 bits.

Optional Feature:
- Macro: MISSILE_CTL_AUTOFIRE_EN.
- Defined: the IDLE launch condition is fire level (fire==1), not fire_edge. Holding fire gives continuous launches, each separated by flight plus COOLDOWN_FRAMES.
- Undefined: edge-only launch as above.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset mid-flight:
  - Stimulus: launch; at ypos=300 pull rst_n low between clock edges.
  - Required: on=0, xpos=0, ypos=0 before the next pclk edge. After release, state is IDLE and no shot pulse.
- Launch and flight:
  - Stimulus: ship_xpos=400, ship_ypos=500, fire edge.
  - Required: next cycle on=1, xpos=400, ypos=480, shot=1 for 1 cycle.
  - Then ypos=472, 464, ... on each frame tick; with ship_xpos changed to 100, xpos stays 400.
- Top exit and cooldown:
  - Stimulus: flight continues until ypos=0 (480/8=60 ticks to reach 0), then one further tick.
  - Required: on=0 after that tick. Fire edges in the next 4 ticks are ignored; a fire edge after the 4th tick launches.
- Launch clamp:
  - Stimulus: ship_ypos=10, fire edge.
  - Required: ypos=0, on=1. The next frame tick gives on=0 and COOLDOWN.
- Hit priority:
  - Stimulus: in FLY, assert hit on the same cycle as a frame_tick.
  - Required: ypos unchanged, on=0 next cycle, state COOLDOWN.
  - Also: hit=1 in IDLE with no fire leaves on=0 and no state change.
- Fire gating (run with and without MISSILE_CTL_AUTOFIRE_EN):
  - Stimulus: hold fire=1 continuously through one full flight and cooldown.
  - Macro undefined: exactly 1 shot pulse.
  - Macro defined: a second shot pulse on the cycle after COOLDOWN returns to IDLE.

Source files
------------

// File: rtl/missile_ctl.sv
// Missile game logic: launches from the ship on fire, climbs SPEED px per frame, cooldown after exit/hit.
// Latency: launch and hit take effect one pclk after the triggering input; outputs are registered.
// No backpressure: free-running, inputs sampled every cycle; fire edges outside IDLE are dropped.
// Optional build macro MISSILE_CTL_AUTOFIRE_EN: launch on fire level instead of fire rising edge.
module missile_ctl #(
    parameter int unsigned SPEED           = 8,
    parameter int unsigned MISSILE_H       = 20,
    parameter int unsigned COOLDOWN_FRAMES = 4
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        fire,
    input  logic [10:0] ship_xpos,
    input  logic [10:0] ship_ypos,
    input  logic        vsync_in,
    input  logic        hit,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic        on,
    output logic        shot
);

    localparam logic [10:0] SPEED_W     = 11'(SPEED);
    localparam logic [10:0] MISSILE_H_W = 11'(MISSILE_H);
    localparam logic [3:0]  COOLDOWN_W  = 4'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLY,
        ST_COOLDOWN
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] xpos_q, xpos_d;
    logic [10:0] ypos_q, ypos_d;
    logic        on_q, on_d;
    logic        shot_q, shot_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        vsync_q;
    logic        fire_q;

    logic        frame_tick;
    logic        fire_edge;
    logic        launch;

    assign frame_tick = vsync_in & ~vsync_q;
    assign fire_edge  = fire & ~fire_q;

`ifdef MISSILE_CTL_AUTOFIRE_EN
    // Held fire relaunches as soon as the cooldown lets go.
    assign launch = fire;
`else
    // A fresh press is needed for every launch.
    assign launch = fire_edge;
`endif

    // Edge-detect history, sampled every cycle regardless of state.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            fire_q  <= 1'b0;
        end else begin
            vsync_q <= vsync_in;
            fire_q  <= fire;
        end
    end

    // State and output registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            xpos_q  <= '0;
            ypos_q  <= '0;
            on_q    <= 1'b0;
            shot_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            on_q    <= on_d;
            shot_q  <= shot_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: launch, flight with hit priority over the frame step, cooldown countdown.
    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        on_d    = on_q;
        shot_d  = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                on_d = 1'b0;
                if (launch) begin
                    xpos_d  = ship_xpos;
                    // Clamp at the top edge rather than wrapping the 11-bit subtract.
                    ypos_d  = (ship_ypos >= MISSILE_H_W) ? (ship_ypos - MISSILE_H_W) : 11'd0;
                    on_d    = 1'b1;
                    shot_d  = 1'b1;
                    state_d = ST_FLY;
                end
            end
            ST_FLY: begin
                if (hit) begin
                    on_d    = 1'b0;
                    cnt_d   = COOLDOWN_W;
                    state_d = ST_COOLDOWN;
                end else if (frame_tick) begin
                    if (ypos_q >= SPEED_W) begin
                        ypos_d = ypos_q - SPEED_W;
                    end else begin
                        // Left the top of the screen; ypos keeps its last value.
                        on_d    = 1'b0;
                        cnt_d   = COOLDOWN_W;
                        state_d = ST_COOLDOWN;
                    end
                end
            end
            ST_COOLDOWN: begin
                on_d = 1'b0;
                if (frame_tick) begin
                    // A zero count cannot occur here, but treat it as expired rather than wrapping.
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                on_d    = 1'b0;
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign xpos = xpos_q;
    assign ypos = ypos_q;
    assign on   = on_q;
    assign shot = shot_q;

endmodule

// File: tb/tb_missile_ctl.sv
// Bench for missile_ctl: a behavioural model pushes the expected outputs each cycle, popped after the edge.
// Latency: one pclk from driven inputs to compared outputs.
// No backpressure in the DUT; the bench drives on negedge and samples 1 ns after posedge.
module tb_missile_ctl;

    logic        pclk;
    logic        rst_n;
    logic        fire;
    logic [10:0] ship_xpos;
    logic [10:0] ship_ypos;
    logic        vsync_in;
    logic        hit;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic        on;
    logic        shot;

    missile_ctl dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .fire      (fire),
        .ship_xpos (ship_xpos),
        .ship_ypos (ship_ypos),
        .vsync_in  (vsync_in),
        .hit       (hit),
        .xpos      (xpos),
        .ypos      (ypos),
        .on        (on),
        .shot      (shot)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    typedef struct packed {
        logic        on;
        logic        shot;
        logic [10:0] x;
        logic [10:0] y;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp;
    int n_err;
    int shots;

    // Reference model state (0 idle, 1 flying, 2 cooldown).
    int          m_state;
    logic [10:0] m_x;
    logic [10:0] m_y;
    logic        m_on;
    logic        m_shot;
    int          m_cnt;
    logic        m_vs;
    logic        m_fire;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_x     = '0;
        m_y     = '0;
        m_on    = 1'b0;
        m_shot  = 1'b0;
        m_cnt   = 0;
        m_vs    = 1'b0;
        m_fire  = 1'b0;
        exp_q.delete();
    endtask

    // Advance the model on the currently driven inputs and queue what the DUT must show after the edge.
    task automatic model_push();
        logic ft;
        logic go;
        exp_t e;
        ft = vsync_in && !m_vs;
`ifdef MISSILE_CTL_AUTOFIRE_EN
        go = fire;
`else
        go = fire && !m_fire;
`endif
        m_shot = 1'b0;
        if (m_state == 0) begin
            if (go) begin
                m_x     = ship_xpos;
                m_y     = (ship_ypos < 11'd20) ? 11'd0 : ship_ypos - 11'd20;
                m_on    = 1'b1;
                m_shot  = 1'b1;
                m_state = 1;
            end
        end else if (m_state == 1) begin
            if (hit || (ft && m_y < 11'd8)) begin
                m_on    = 1'b0;
                m_cnt   = 4;
                m_state = 2;
            end else if (ft) begin
                m_y = m_y - 11'd8;
            end
        end else begin
            if (ft) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_state = 0;
            end
        end
        m_vs    = vsync_in;
        m_fire  = fire;
        e.on    = m_on;
        e.shot  = m_shot;
        e.x     = m_x;
        e.y     = m_y;
        exp_q.push_back(e);
    endtask

    // One clock: queue expectation, take the edge, compare, return at the next negedge.
    task automatic step();
        exp_t e;
        model_push();
        @(posedge pclk);
        #1;
        e = exp_q.pop_front();
        chk("on", 32'(on), 32'(e.on));
        chk("shot", 32'(shot), 32'(e.shot));
        chk("xpos", 32'(xpos), 32'(e.x));
        chk("ypos", 32'(ypos), 32'(e.y));
        if (shot === 1'b1) shots++;
        @(negedge pclk);
    endtask

    task automatic tick();
        vsync_in = 1'b1;
        step();
        vsync_in = 1'b0;
        step();
    endtask

    task automatic cooldown4();
        repeat (4) tick();
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        shots     = 0;
        rst_n     = 1'b0;
        fire      = 1'b0;
        hit       = 1'b0;
        vsync_in  = 1'b0;
        ship_xpos = '0;
        ship_ypos = '0;
        model_reset();

        // Reset state.
        #2;
        chk("rst_on", 32'(on), 32'd0);
        chk("rst_shot", 32'(shot), 32'd0);
        chk("rst_xpos", 32'(xpos), 32'd0);
        chk("rst_ypos", 32'(ypos), 32'd0);
        @(negedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        step();

        // Launch and flight; ship moving mid-flight must not drag the missile.
        ship_xpos = 11'd400;
        ship_ypos = 11'd500;
        fire = 1'b1;
        step();
        chk("launch_on", 32'(on), 32'd1);
        chk("launch_x", 32'(xpos), 32'd400);
        chk("launch_y", 32'(ypos), 32'd480);
        chk("launch_shot", 32'(shot), 32'd1);
        fire = 1'b0;
        step();
        chk("shot_once", 32'(shot), 32'd0);
        ship_xpos = 11'd100;
        tick();
        chk("fly_y1", 32'(ypos), 32'd472);
        tick();
        chk("fly_y2", 32'(ypos), 32'd464);
        chk("fly_x_hold", 32'(xpos), 32'd400);

        // Top exit.
        repeat (58) tick();
        chk("top_y0", 32'(ypos), 32'd0);
        chk("top_on", 32'(on), 32'd1);
        tick();
        chk("exit_on", 32'(on), 32'd0);
        chk("exit_y_hold", 32'(ypos), 32'd0);

        // Fire edges during cooldown are dropped; one after the 4th tick launches.
        for (int i = 0; i < 4; i++) begin
            fire = 1'b1;
            step();
            fire = 1'b0;
            step();
            chk("cd_fire_ignored", 32'(on), 32'd0);
            tick();
        end
        fire = 1'b1;
        step();
        chk("cd_relaunch", 32'(on), 32'd1);
        chk("cd_relaunch_x", 32'(xpos), 32'd100);
        fire = 1'b0;
        hit = 1'b1;
        step();
        chk("hit_off", 32'(on), 32'd0);
        hit = 1'b0;
        cooldown4();

        // Asynchronous reset mid-flight.
        ship_xpos = 11'd200;
        ship_ypos = 11'd320;
        fire = 1'b1;
        step();
        fire = 1'b0;
        step();
        chk("pre_rst_y", 32'(ypos), 32'd300);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_on", 32'(on), 32'd0);
        chk("async_rst_x", 32'(xpos), 32'd0);
        chk("async_rst_y", 32'(ypos), 32'd0);
        model_reset();
        @(negedge pclk);
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_shot", 32'(shot), 32'd0);

        // Launch clamp near the top.
        ship_ypos = 11'd10;
        fire = 1'b1;
        step();
        chk("clamp_y", 32'(ypos), 32'd0);
        chk("clamp_on", 32'(on), 32'd1);
        fire = 1'b0;
        step();
        tick();
        chk("clamp_exit", 32'(on), 32'd0);
        cooldown4();

        // Hit beats a simultaneous frame tick.
        ship_ypos = 11'd500;
        fire = 1'b1;
        step();
        fire = 1'b0;
        step();
        tick();
        hit = 1'b1;
        vsync_in = 1'b1;
        step();
        chk("hitpri_y", 32'(ypos), 32'd472);
        chk("hitpri_on", 32'(on), 32'd0);
        hit = 1'b0;
        vsync_in = 1'b0;
        step();
        cooldown4();

        // Hit in IDLE is ignored; a following fire still launches.
        hit = 1'b1;
        repeat (3) step();
        chk("idle_hit_on", 32'(on), 32'd0);
        hit = 1'b0;
        fire = 1'b1;
        step();
        chk("idle_hit_launch", 32'(on), 32'd1);
        fire = 1'b0;
        hit = 1'b1;
        step();
        hit = 1'b0;
        cooldown4();

        // Fire held through a whole flight and cooldown.
        shots = 0;
        ship_ypos = 11'd40;
        fire = 1'b1;
        step();
        repeat (3) tick();
        cooldown4();
        repeat (2) step();
        fire = 1'b0;
`ifdef MISSILE_CTL_AUTOFIRE_EN
        chk("held_fire_shots", 32'(shots), 32'd2);
`else
        chk("held_fire_shots", 32'(shots), 32'd1);
`endif
        hit = 1'b1;
        step();
        hit = 1'b0;
        cooldown4();
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
